// File: rtl/vx_rop_blend_pipe.sv
// Pipelined multi-lane RGBA blender: factor select, normalised multiply, blend equation + saturate.
// Latency: 3 cycles from input handshake to valid_out, full throughput of 1 beat/cycle.
// Backpressure: the whole pipe stalls while valid_out && !ready_out; ready_in = ~s2_vld | ready_out.
// Option: define ROP_BLEND_MINMAX_EN to build the MIN/MAX equations (otherwise eq 3/4 act as ADD).
module vx_rop_blend_pipe #(
    parameter int NUM_LANES = 4,
    parameter int CW        = 8,
    parameter int TAG_W     = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      valid_in,
    output logic                      ready_in,
    input  logic [NUM_LANES-1:0]      mask_in,
    input  logic [TAG_W-1:0]          tag_in,
    input  logic [NUM_LANES*4*CW-1:0] src_in,
    input  logic [NUM_LANES*4*CW-1:0] dst_in,
    input  logic [4*CW-1:0]           cst_in,
    input  logic [3:0]                func_src_rgb,
    input  logic [3:0]                func_src_a,
    input  logic [3:0]                func_dst_rgb,
    input  logic [3:0]                func_dst_a,
    input  logic [2:0]                eq_rgb,
    input  logic [2:0]                eq_a,
    output logic                      valid_out,
    input  logic                      ready_out,
    output logic [NUM_LANES-1:0]      mask_out,
    output logic [TAG_W-1:0]          tag_out,
    output logic [NUM_LANES*4*CW-1:0] color_out
);
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

    typedef logic [NUM_LANES-1:0][3:0][CW-1:0] pix_t;

    // Blend factor for one channel; "1-x" is M-x, code 14 saturates RGB and is M on alpha.
    function automatic logic [CW-1:0] sel_factor(
        input logic [3:0]    code,
        input logic          is_a,
        input logic [CW-1:0] s,
        input logic [CW-1:0] sa,
        input logic [CW-1:0] d,
        input logic [CW-1:0] da,
        input logic [CW-1:0] k,
        input logic [CW-1:0] ka
    );
        logic [CW-1:0] sat;
        sat = (sa < (CMAX - da)) ? sa : (CMAX - da);
        case (code)
            4'd1:    return CMAX;
            4'd2:    return s;
            4'd3:    return CMAX - s;
            4'd4:    return sa;
            4'd5:    return CMAX - sa;
            4'd6:    return d;
            4'd7:    return CMAX - d;
            4'd8:    return da;
            4'd9:    return CMAX - da;
            4'd10:   return k;
            4'd11:   return CMAX - k;
            4'd12:   return ka;
            4'd13:   return CMAX - ka;
            4'd14:   return is_a ? CMAX : sat;
            default: return '0;
        endcase
    endfunction

    // round(c*f/M) without a divider; the sums never exceed 2*CW bits for CW-bit operands.
    function automatic logic [CW-1:0] norm_mul(input logic [CW-1:0] c, input logic [CW-1:0] f);
        logic [2*CW-1:0] x;
        logic [2*CW-1:0] y;
        x = {{CW{1'b0}}, c} * {{CW{1'b0}}, f};
        x = x + ((2*CW)'(1) << (CW-1));
        y = x + (x >> CW);
        return CW'(y >> CW);
    endfunction

    // Arithmetic blend equations with clamping; unlisted codes fall back to ADD.
    function automatic logic [CW-1:0] blend_eq(input logic [2:0] eq, input logic [CW-1:0] s,
                                               input logic [CW-1:0] d);
        logic [CW:0] sum;
        sum = {1'b0, s} + {1'b0, d};
        case (eq)
            3'd1:    return (s >= d) ? s - d : '0;
            3'd2:    return (d >= s) ? d - s : '0;
            default: return sum[CW] ? CMAX : sum[CW-1:0];
        endcase
    endfunction

    pix_t               src_w;
    pix_t               dst_w;
    logic [3:0][CW-1:0] cst_w;

    assign src_w = src_in;
    assign dst_w = dst_in;
    assign cst_w = cst_in;

    logic en;
    logic s0_vld_q, s1_vld_q, s2_vld_q;

    assign en       = ~s2_vld_q | ready_out;
    assign ready_in = en;

    // Stage 0 state: selected factors plus the raw colours they apply to.
    pix_t                 s0_sf_d, s0_df_d, s0_sf_q, s0_df_q, s0_src_q, s0_dst_q;
    logic [NUM_LANES-1:0] s0_mask_q;
    logic [TAG_W-1:0]     s0_tag_q;
    logic [2:0]           s0_eq_rgb_q, s0_eq_a_q;

    // Stage 1 state: normalised products, raw colours kept for pass-through and MIN/MAX.
    pix_t                 s1_qs_d, s1_qd_d, s1_qs_q, s1_qd_q, s1_dst_q;
`ifdef ROP_BLEND_MINMAX_EN
    pix_t                 s1_src_q;
`endif
    logic [NUM_LANES-1:0] s1_mask_q;
    logic [TAG_W-1:0]     s1_tag_q;
    logic [2:0]           s1_eq_rgb_q, s1_eq_a_q;

    // Stage 2 state: final colours, visible on the outputs.
    pix_t                 s2_color_d, s2_color_q;
    logic [NUM_LANES-1:0] s2_mask_q;
    logic [TAG_W-1:0]     s2_tag_q;

    // Pick source/destination factors per lane and channel; channel 3 (alpha) uses the _a selectors.
    always_comb begin
        s0_sf_d = '0;
        s0_df_d = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int c = 0; c < 4; c++) begin
                s0_sf_d[l][c] = sel_factor((c == 3) ? func_src_a : func_src_rgb, c == 3,
                                           src_w[l][c], src_w[l][3], dst_w[l][c], dst_w[l][3],
                                           cst_w[c], cst_w[3]);
                s0_df_d[l][c] = sel_factor((c == 3) ? func_dst_a : func_dst_rgb, c == 3,
                                           src_w[l][c], src_w[l][3], dst_w[l][c], dst_w[l][3],
                                           cst_w[c], cst_w[3]);
            end
        end
    end

    // Scale source and destination colours by their factors.
    always_comb begin
        s1_qs_d = '0;
        s1_qd_d = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int c = 0; c < 4; c++) begin
                s1_qs_d[l][c] = norm_mul(s0_src_q[l][c], s0_sf_q[l][c]);
                s1_qd_d[l][c] = norm_mul(s0_dst_q[l][c], s0_df_q[l][c]);
            end
        end
    end

    // Apply the blend equation; masked-off lanes keep the destination colour untouched.
    always_comb begin
        logic [2:0]    eq_sel;
        logic [CW-1:0] res;
        s2_color_d = '0;
        eq_sel     = '0;
        res        = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int c = 0; c < 4; c++) begin
                eq_sel = (c == 3) ? s1_eq_a_q : s1_eq_rgb_q;
                res    = blend_eq(eq_sel, s1_qs_q[l][c], s1_qd_q[l][c]);
`ifdef ROP_BLEND_MINMAX_EN
                if (eq_sel == 3'd3) begin
                    res = (s1_src_q[l][c] < s1_dst_q[l][c]) ? s1_src_q[l][c] : s1_dst_q[l][c];
                end else if (eq_sel == 3'd4) begin
                    res = (s1_src_q[l][c] > s1_dst_q[l][c]) ? s1_src_q[l][c] : s1_dst_q[l][c];
                end
`endif
                s2_color_d[l][c] = s1_mask_q[l] ? res : s1_dst_q[l][c];
            end
        end
    end

    // Stage valids and output registers; the pipe moves only as a whole on en.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s0_vld_q   <= 1'b0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_color_q <= '0;
            s2_mask_q  <= '0;
            s2_tag_q   <= '0;
        end else if (en) begin
            s0_vld_q <= valid_in;
            s1_vld_q <= s0_vld_q;
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_color_q <= s2_color_d;
                s2_mask_q  <= s1_mask_q;
                s2_tag_q   <= s1_tag_q;
            end
        end
    end

    // Datapath registers load only when a valid beat moves into the stage.
    always_ff @(posedge clk) begin
        if (en && valid_in) begin
            s0_sf_q     <= s0_sf_d;
            s0_df_q     <= s0_df_d;
            s0_src_q    <= src_w;
            s0_dst_q    <= dst_w;
            s0_mask_q   <= mask_in;
            s0_tag_q    <= tag_in;
            s0_eq_rgb_q <= eq_rgb;
            s0_eq_a_q   <= eq_a;
        end
        if (en && s0_vld_q) begin
            s1_qs_q     <= s1_qs_d;
            s1_qd_q     <= s1_qd_d;
            s1_dst_q    <= s0_dst_q;
`ifdef ROP_BLEND_MINMAX_EN
            s1_src_q    <= s0_src_q;
`endif
            s1_mask_q   <= s0_mask_q;
            s1_tag_q    <= s0_tag_q;
            s1_eq_rgb_q <= s0_eq_rgb_q;
            s1_eq_a_q   <= s0_eq_a_q;
        end
    end

    assign valid_out = s2_vld_q;
    assign color_out = s2_color_q;
    assign mask_out  = s2_mask_q;
    assign tag_out   = s2_tag_q;

endmodule

// File: tb/tb_vx_rop_blend_pipe.sv
// Self-checking bench for vx_rop_blend_pipe (CW=8, NUM_LANES=4, TAG_W=8).
// Directed blend cases, backpressure, reset-in-flight, then randomized traffic vs. a reference model.
// Outputs are sampled on the falling edge; inputs change 1ns after the rising edge.
module tb_vx_rop_blend_pipe;
    typedef struct {
        logic [3:0]   mask;
        logic [7:0]   tag;
        logic [127:0] src;
        logic [127:0] dst;
        logic [31:0]  cst;
        logic [3:0]   fsr, fsa, fdr, fda;
        logic [2:0]   eqr, eqa;
    } beat_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         valid_in, ready_in, valid_out, ready_out;
    logic [3:0]   mask_in, mask_out;
    logic [7:0]   tag_in, tag_out;
    logic [127:0] src_in, dst_in, color_out;
    logic [31:0]  cst_in;
    logic [3:0]   func_src_rgb, func_src_a, func_dst_rgb, func_dst_a;
    logic [2:0]   eq_rgb, eq_a;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    beat_t        cur;
    logic [127:0] exp_col_q[$];
    logic [7:0]   exp_tag_q[$];
    logic [3:0]   exp_mask_q[$];
    logic [7:0]   seen_tags[$];
    logic         prev_stall = 1'b0;
    logic [127:0] prev_col;

    always #5 clk = ~clk;

    vx_rop_blend_pipe #(.NUM_LANES(4), .CW(8), .TAG_W(8)) dut (
        .clk(clk), .resetn(resetn),
        .valid_in(valid_in), .ready_in(ready_in),
        .mask_in(mask_in), .tag_in(tag_in),
        .src_in(src_in), .dst_in(dst_in), .cst_in(cst_in),
        .func_src_rgb(func_src_rgb), .func_src_a(func_src_a),
        .func_dst_rgb(func_dst_rgb), .func_dst_a(func_dst_a),
        .eq_rgb(eq_rgb), .eq_a(eq_a),
        .valid_out(valid_out), .ready_out(ready_out),
        .mask_out(mask_out), .tag_out(tag_out), .color_out(color_out)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Factor table, straight from the code list (M = 255).
    function automatic int fac(int code, bit isa, int s, int sa, int d, int da, int k, int ka);
        case (code)
            1:  return 255;
            2:  return s;
            3:  return 255 - s;
            4:  return sa;
            5:  return 255 - sa;
            6:  return d;
            7:  return 255 - d;
            8:  return da;
            9:  return 255 - da;
            10: return k;
            11: return 255 - k;
            12: return ka;
            13: return 255 - ka;
            14: return isa ? 255 : ((sa < 255 - da) ? sa : 255 - da);
            default: return 0;
        endcase
    endfunction

    // Expected output colours of one beat, using integer round-half-up division by M.
    function automatic logic [127:0] model(beat_t b);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 4; c++) begin
                int s, d, sa, da, k, ka, fs, fd, ps, pd, o, eq;
                bit isa;
                s   = int'(b.src[(l*4+c)*8 +: 8]);
                d   = int'(b.dst[(l*4+c)*8 +: 8]);
                sa  = int'(b.src[(l*4+3)*8 +: 8]);
                da  = int'(b.dst[(l*4+3)*8 +: 8]);
                k   = int'(b.cst[c*8 +: 8]);
                ka  = int'(b.cst[31:24]);
                isa = (c == 3);
                fs  = fac(isa ? int'(b.fsa) : int'(b.fsr), isa, s, sa, d, da, k, ka);
                fd  = fac(isa ? int'(b.fda) : int'(b.fdr), isa, s, sa, d, da, k, ka);
                ps  = (2 * s * fs + 255) / 510;
                pd  = (2 * d * fd + 255) / 510;
                eq  = isa ? int'(b.eqa) : int'(b.eqr);
                if (!b.mask[l]) o = d;
                else if (eq == 1) o = (ps > pd) ? ps - pd : 0;
                else if (eq == 2) o = (pd > ps) ? pd - ps : 0;
`ifdef ROP_BLEND_MINMAX_EN
                else if (eq == 3) o = (s < d) ? s : d;
                else if (eq == 4) o = (s > d) ? s : d;
`endif
                else o = (ps + pd > 255) ? 255 : ps + pd;
                r[(l*4+c)*8 +: 8] = o[7:0];
            end
        end
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.mask = 4'($urandom);
        b.tag  = 8'($urandom);
        b.src  = {$urandom, $urandom, $urandom, $urandom};
        b.dst  = {$urandom, $urandom, $urandom, $urandom};
        b.cst  = $urandom;
        b.fsr  = 4'($urandom_range(15));
        b.fsa  = 4'($urandom_range(15));
        b.fdr  = 4'($urandom_range(15));
        b.fda  = 4'($urandom_range(15));
        b.eqr  = 3'($urandom_range(7));
        b.eqa  = 3'($urandom_range(7));
        return b;
    endfunction

    task automatic apply(input beat_t b);
        cur          = b;
        mask_in      = b.mask;
        tag_in       = b.tag;
        src_in       = b.src;
        dst_in       = b.dst;
        cst_in       = b.cst;
        func_src_rgb = b.fsr;
        func_src_a   = b.fsa;
        func_dst_rgb = b.fdr;
        func_dst_a   = b.fda;
        eq_rgb       = b.eqr;
        eq_a         = b.eqa;
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input beat_t b);
        bit ok;
        ok = 1'b0;
        apply(b);
        valid_in = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = ready_in;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        valid_in = 1'b0;
    endtask

    // Waits for the next output beat; lat counts falling edges since the accepting edge.
    task automatic wait_out(output logic [127:0] col, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        col  = '0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(negedge clk);
            if (valid_out) begin
                seen = 1'b1;
                lat  = i;
                col  = color_out;
            end
        end
        if (!seen) chk("out_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every delivered beat in order and check stall stability.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_vld", valid_out, 1);
                chk("hold_col", color_out, prev_col);
            end
            if (valid_out && ready_out) begin
                n_out++;
                seen_tags.push_back(tag_out);
                if (exp_col_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    chk("sb_col", color_out, exp_col_q.pop_front());
                    chk("sb_tag", tag_out, exp_tag_q.pop_front());
                    chk("sb_mask", mask_out, exp_mask_q.pop_front());
                end
            end
            if (valid_in && ready_in) begin
                exp_col_q.push_back(model(cur));
                exp_tag_q.push_back(cur.tag);
                exp_mask_q.push_back(cur.mask);
            end
            prev_stall = valid_out && !ready_out;
            prev_col   = color_out;
        end
    end

    initial begin
        beat_t        b;
        logic [127:0] col;
        logic [7:0]   exp8;
        int           lat, base, sent;
        bit           acc, stale;

        resetn    = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
        b         = rand_beat();
        apply(b);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", valid_out, 0);
        chk("rst_col", color_out, 0);
        chk("rst_tag", tag_out, 0);
        chk("rst_mask", mask_out, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_rdy", ready_in, 1);
        @(posedge clk);
        #1;

        // SRC_A / 1-SRC_A over-blend: 0x80*0x80/M + 0x40*0x7F/M = 0x40 + 0x20.
        b = rand_beat();
        b.mask[0] = 1'b1; b.src[31:24] = 8'h80; b.src[23:16] = 8'h80; b.dst[23:16] = 8'h40;
        b.fsr = 4'd4; b.fdr = 4'd5; b.eqr = 3'd0;
        send(b);
        wait_out(col, lat);
        chk("latency", lat, 3);
        chk("over_r", col[23:16], 8'h60);

        // ONE/ONE ADD saturates.
        b = rand_beat();
        b.mask[0] = 1'b1; b.src[23:16] = 8'hC0; b.dst[23:16] = 8'h80;
        b.fsr = 4'd1; b.fdr = 4'd1; b.eqr = 3'd0;
        send(b);
        wait_out(col, lat);
        chk("add_sat_r", col[23:16], 8'hFF);

        // ONE/ONE SUB clamps at zero.
        b.src[23:16] = 8'h40; b.eqr = 3'd1;
        send(b);
        wait_out(col, lat);
        chk("sub_clamp_r", col[23:16], 8'h00);

        // ALPHA_SAT: RGB factor min(C0, FF-80)=7F, alpha factor FF.
        b = rand_beat();
        b.mask[0] = 1'b1; b.src[31:24] = 8'hC0; b.dst[31:24] = 8'h80; b.src[23:16] = 8'hFF;
        b.fsr = 4'd14; b.fsa = 4'd14; b.fdr = 4'd0; b.fda = 4'd0; b.eqr = 3'd0; b.eqa = 3'd0;
        send(b);
        wait_out(col, lat);
        chk("asat_r", col[23:16], 8'h7F);
        chk("asat_a", col[31:24], 8'hC0);

        // Masked-off lane passes destination through; MIN depends on the build option.
        b = rand_beat();
        b.mask[1] = 1'b0; b.mask[0] = 1'b1;
        b.src[23:16] = 8'h30; b.dst[23:16] = 8'h50;
        b.fsr = 4'd1; b.fdr = 4'd1; b.eqr = 3'd3;
        send(b);
        wait_out(col, lat);
        chk("inactive_lane", col[63:32], b.dst[63:32]);
`ifdef ROP_BLEND_MINMAX_EN
        exp8 = 8'h30;
`else
        exp8 = 8'h80;
`endif
        chk("min_r", col[23:16], exp8);

        // Backpressure: four back-to-back beats while the sink stalls for five cycles.
        seen_tags.delete();
        base      = n_out;
        ready_out = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                #1 ready_out = 1'b1;
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    b = rand_beat();
                    b.tag = 8'(i);
                    send(b);
                end
                @(negedge clk);
                chk("bp_rdy_low", ready_in, 0);
                @(posedge clk);
                #1;
                b = rand_beat();
                b.tag = 8'd3;
                send(b);
            end
        join
        for (int i = 0; i < 40 && n_out < base + 4; i++) @(posedge clk);
        #1;
        chk("bp_count", n_out - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_order", (seen_tags.size() > i) ? seen_tags[i] : 8'hEE, 8'(i));
        end

        // Reset with two beats in flight: both must vanish.
        b = rand_beat();
        send(b);
        b = rand_beat();
        send(b);
        resetn = 1'b0;
        exp_col_q.delete();
        exp_tag_q.delete();
        exp_mask_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("rst_flight_vld", valid_out, 0);
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid_out) stale = 1'b1;
        end
        chk("rst_no_stale", stale, 0);
        @(posedge clk);
        #1;

        // Randomized traffic with random sink stalls.
        sent = 0;
        for (int n = 0; n < 3000 && sent < 300; n++) begin
            if (!valid_in && $urandom_range(3) != 0) begin
                b = rand_beat();
                apply(b);
                valid_in = 1'b1;
            end
            ready_out = ($urandom_range(3) != 0);
            @(negedge clk);
            acc = valid_in && ready_in;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                valid_in = 1'b0;
            end
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        for (int i = 0; i < 50 && exp_col_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("rand_sent", sent, 300);
        chk("drain_empty", exp_col_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
